enc_frame_sequencer: RTL and testbench
======================================

ENC_FRAME_SEQUENCER -- requirements
Module: enc_frame_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: input FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter IFG, default 2: K28.5 gap symbols after each EOF (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pushin  input  1  upstream byte valid.
REQ-006 SHALL have port firstin  input  1  byte is first of frame; qualified by pushin.
REQ-007 SHALL have port lastin  input  1  byte is last of frame; qualified by pushin.
REQ-008 SHALL have port datain  input  8  upstream payload byte.
REQ-009 SHALL have port stopin  output  1  backpressure: FIFO full, upstream must not push.
REQ-010 SHALL have port startout  output  1  pulse to encoder forcing running disparity to negative.
REQ-011 SHALL have port pushout  output  1  symbol valid to encoder.
REQ-012 SHALL have port kout  output  1  symbol is a K character.
REQ-013 SHALL have port dataout  output  8  symbol byte to encoder.
REQ-014 SHALL have port busy  output  1  high in SOF, DATA, EOF states.
REQ-015 SHALL have port dropout  output  1  one-cycle pulse when an orphan byte is discarded.

Function
REQ-016 SHALL store {firstin, lastin, datain} in a DEPTH-entry FIFO; push on pushin && !stopin.
REQ-017 SHALL drive stopin combinationally = (count == DEPTH); push while full SHALL be ignored even if a pop occurs in the same cycle.
REQ-018 SHALL support simultaneous push and pop when not full; count unchanged, pointers wrap modulo DEPTH.
REQ-019 SHALL implement FSM states INIT, IDLE, SOF, DATA, EOF, GAP; all outputs registered, updated at the same edge as the state.
REQ-020 INIT: SHALL register startout=1, pushout=0 for exactly one cycle, then go to IDLE.
REQ-021 IDLE: SHALL emit K28.5 (kout=1, dataout=0xBC, pushout=1) each cycle.
REQ-022 IDLE with FIFO head first=1: SHALL go to SOF without popping.
REQ-023 IDLE with FIFO head first=0: SHALL pop and discard it, pulse dropout, stay IDLE.
REQ-024 SOF: SHALL emit K27.7 (0xFB, kout=1) for one cycle, then go to DATA.
REQ-025 DATA with FIFO non-empty: SHALL pop head and emit it (kout=0, dataout=byte); head first flag SHALL be ignored.
REQ-026 DATA, popped head last=1: SHALL go to EOF.
REQ-027 DATA with FIFO empty (underrun): SHALL emit K28.5 fill and stay in DATA.
REQ-028 EOF: SHALL emit K29.7 (0xFD, kout=1) for one cycle.
REQ-029 EOF exit: SHALL go to GAP loading gap counter with IFG, or to IDLE directly if IFG==0.
REQ-030 GAP: SHALL emit K28.5 and decrement the counter; SHALL go to IDLE after exactly IFG gap symbols.
REQ-031 Outside INIT, pushout SHALL be 1 every cycle (continuous symbol stream); startout SHALL be 0.
REQ-032 Frame of one byte (first=1,last=1) SHALL produce SOF, one data symbol, EOF.
REQ-033 Latency: byte pushed at edge E0 into empty FIFO while IDLE -> K27.7 on outputs after E1, byte after E2.

Reset
REQ-034 reset_n low SHALL asynchronously clear the FIFO (count=0), gap counter, state=INIT, and all outputs to 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame with no EOF; after release, the sequence SHALL restart at INIT.
REQ-036 First rising edge after reset_n release SHALL register startout=1.

Verification
REQ-037 Reset release -> edge1: startout=1,pushout=0; edge2: pushout=1,kout=1,dataout=0xBC; continuous 0xBC thereafter.
REQ-038 Push frame 0x11(first),0x22,0x33(last), IFG=2 -> stream FB(K),11,22,33,FD(K),BC,BC, then IDLE BC; busy high SOF..EOF only.
REQ-039 Push 5 bytes back-to-back, DEPTH=4, while DATA stalled behind SOF -> stopin rises at count 4; 5th push dropped; no FIFO corruption.
REQ-040 Push 0x55 with first=0 while IDLE -> dropout pulse one cycle, no SOF, stream stays 0xBC.
REQ-041 Frame first byte only, then 3-cycle pause, then last byte -> FB, byte, BC,BC,BC fill (kout=1), last byte, FD.
REQ-042 Assert reset_n low during DATA -> outputs 0 immediately (async), FIFO empty; after release INIT startout pulse, no FD emitted.

Source files
------------

// File: rtl/enc_frame_sequencer_if.sv
// rtl/enc_frame_sequencer_if.sv - upstream byte bus and encoder symbol bus for the frame sequencer
interface enc_frame_sequencer_if;
  logic       pushin;
  logic       firstin;
  logic       lastin;
  logic [7:0] datain;
  logic       stopin;
  logic       startout;
  logic       pushout;
  logic       kout;
  logic [7:0] dataout;
  logic       busy;
  logic       dropout;

  modport master (
    output pushin, firstin, lastin, datain,
    input  stopin, startout, pushout, kout, dataout, busy, dropout
  );

  modport slave (
    input  pushin, firstin, lastin, datain,
    output stopin, startout, pushout, kout, dataout, busy, dropout
  );
endinterface

// File: rtl/enc_frame_sequencer.sv
// rtl/enc_frame_sequencer.sv - buffers framed bytes and emits an 8b/10b symbol stream (SOF, data, EOF, gap, idle fill)
module enc_frame_sequencer #(
  parameter int DEPTH = 4,
  parameter int IFG   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  enc_frame_sequencer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SOF,
    S_DATA,
    S_EOF,
    S_GAP
  } state_t;

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  logic [3:0]    r_gap;
  logic          r_last;
  logic          r_startout;
  logic          r_pushout;
  logic          r_kout;
  logic [7:0]    r_dataout;
  logic          r_busy;
  logic          r_dropout;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [9:0]    w_head;

  state_t        w_state_nx;
  logic [3:0]    w_gap_nx;
  logic          w_last_nx;
  logic          w_startout_nx;
  logic          w_pushout_nx;
  logic          w_kout_nx;
  logic [7:0]    w_dataout_nx;
  logic          w_busy_nx;
  logic          w_dropout_nx;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.pushin && !w_full;
  assign w_head  = r_mem[r_rd_ptr];

  assign bus.stopin   = w_full;
  assign bus.startout = r_startout;
  assign bus.pushout  = r_pushout;
  assign bus.kout     = r_kout;
  assign bus.dataout  = r_dataout;
  assign bus.busy     = r_busy;
  assign bus.dropout  = r_dropout;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.firstin, bus.lastin, bus.datain};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_INIT;
      r_gap      <= '0;
      r_last     <= 1'b0;
      r_startout <= 1'b0;
      r_pushout  <= 1'b0;
      r_kout     <= 1'b0;
      r_dataout  <= '0;
      r_busy     <= 1'b0;
      r_dropout  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_gap      <= w_gap_nx;
      r_last     <= w_last_nx;
      r_startout <= w_startout_nx;
      r_pushout  <= w_pushout_nx;
      r_kout     <= w_kout_nx;
      r_dataout  <= w_dataout_nx;
      r_busy     <= w_busy_nx;
      r_dropout  <= w_dropout_nx;
    end
  end

  // Registered outputs describe the state being entered, so the symbol on
  // the bus always matches r_state for that cycle (INIT's pulse excepted).
  always_comb begin
    w_state_nx    = r_state;
    w_gap_nx      = r_gap;
    w_last_nx     = r_last;
    w_pop         = 1'b0;
    w_startout_nx = 1'b0;
    w_pushout_nx  = 1'b1;
    w_kout_nx     = 1'b1;
    w_dataout_nx  = K28_5;
    w_busy_nx     = 1'b0;
    w_dropout_nx  = 1'b0;

    case (r_state)
      S_INIT: w_state_nx = S_IDLE;
      S_IDLE: begin
        if (!w_empty) begin
          if (w_head[9]) begin
            w_state_nx = S_SOF;
          end else begin
            w_pop        = 1'b1;
            w_dropout_nx = 1'b1;
          end
        end
      end
      S_SOF:  w_state_nx = S_DATA;
      S_DATA: begin
        if (r_last) w_state_nx = S_EOF;
      end
      S_EOF: begin
        if (IFG == 0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_GAP;
          w_gap_nx   = 4'(IFG);
        end
      end
      S_GAP: begin
        if (r_gap <= 4'd1) begin
          w_state_nx = S_IDLE;
          w_gap_nx   = '0;
        end else begin
          w_gap_nx   = r_gap - 4'd1;
        end
      end
      default: w_state_nx = S_INIT;
    endcase

    if (r_state == S_INIT) begin
      w_startout_nx = 1'b1;
      w_pushout_nx  = 1'b0;
      w_kout_nx     = 1'b0;
      w_dataout_nx  = '0;
    end else begin
      case (w_state_nx)
        S_SOF: begin
          w_dataout_nx = K27_7;
          w_busy_nx    = 1'b1;
        end
        S_DATA: begin
          w_busy_nx = 1'b1;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_kout_nx    = 1'b0;
            w_dataout_nx = w_head[7:0];
            w_last_nx    = w_head[8];
          end else begin
            w_last_nx    = 1'b0;
          end
        end
        S_EOF: begin
          w_dataout_nx = K29_7;
          w_busy_nx    = 1'b1;
          w_last_nx    = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_frame_sequencer.sv
// tb/tb_enc_frame_sequencer.sv - directed self-checking bench for enc_frame_sequencer
module tb_enc_frame_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  enc_frame_sequencer_if bus ();

  enc_frame_sequencer #(
    .DEPTH (4),
    .IFG   (2)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic p, input logic f, input logic l, input logic [7:0] d);
    bus.pushin  = p;
    bus.firstin = f;
    bus.lastin  = l;
    bus.datain  = d;
    tick();
    bus.pushin  = 1'b0;
    bus.firstin = 1'b0;
    bus.lastin  = 1'b0;
    bus.datain  = 8'h00;
  endtask

  task automatic sym(input string tag, input logic k, input logic [7:0] d);
    chk(tag, 32'({bus.startout, bus.pushout, bus.kout, bus.dataout}), 32'({1'b0, 1'b1, k, d}));
  endtask

  task automatic all_zero(input string tag);
    chk(tag, 32'({bus.startout, bus.pushout, bus.kout, bus.dataout, bus.busy, bus.dropout, bus.stopin}), 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.pushin  = 1'b0;
    bus.firstin = 1'b0;
    bus.lastin  = 1'b0;
    bus.datain  = 8'h00;
    repeat (3) tick();
    all_zero("reset_state");

    reset_n = 1'b1;
    tick();
    chk("init_start", 32'({bus.startout, bus.pushout}), 32'b10);
    tick();
    sym("idle0", 1'b1, 8'hBC);
    for (int i = 0; i < 3; i++) begin
      tick();
      sym($sformatf("idle_fill%0d", i), 1'b1, 8'hBC);
    end

    // three-byte frame, latency and IFG=2 gap
    cyc(1, 1, 0, 8'h11); sym("f3_e0", 1'b1, 8'hBC);
    cyc(1, 0, 0, 8'h22); sym("f3_sof", 1'b1, 8'hFB); chk("f3_busy_sof", 32'(bus.busy), 32'd1);
    cyc(1, 0, 1, 8'h33); sym("f3_d11", 1'b0, 8'h11);
    tick();              sym("f3_d22", 1'b0, 8'h22);
    tick();              sym("f3_d33", 1'b0, 8'h33); chk("f3_busy_data", 32'(bus.busy), 32'd1);
    tick();              sym("f3_eof", 1'b1, 8'hFD); chk("f3_busy_eof", 32'(bus.busy), 32'd1);
    tick();              sym("f3_gap0", 1'b1, 8'hBC); chk("f3_busy_gap", 32'(bus.busy), 32'd0);
    tick();              sym("f3_gap1", 1'b1, 8'hBC);
    tick();              sym("f3_idle", 1'b1, 8'hBC); chk("f3_busy_idle", 32'(bus.busy), 32'd0);

    // single-byte frame
    cyc(1, 1, 1, 8'h77); sym("f1_e0", 1'b1, 8'hBC);
    tick();              sym("f1_sof", 1'b1, 8'hFB);
    tick();              sym("f1_d77", 1'b0, 8'h77);
    tick();              sym("f1_eof", 1'b1, 8'hFD);
    repeat (3) tick();
    sym("f1_idle", 1'b1, 8'hBC);

    // orphan byte while idle
    cyc(1, 0, 0, 8'h55); sym("orph_e0", 1'b1, 8'hBC); chk("orph_nodrop0", 32'(bus.dropout), 32'd0);
    tick();              sym("orph_e1", 1'b1, 8'hBC); chk("orph_drop", 32'(bus.dropout), 32'd1);
    tick();              sym("orph_e2", 1'b1, 8'hBC); chk("orph_drop_end", 32'(bus.dropout), 32'd0);
    chk("orph_busy", 32'(bus.busy), 32'd0);

    // underrun: first byte, 3-cycle fill, last byte
    cyc(1, 1, 0, 8'hA1); sym("ur_e0", 1'b1, 8'hBC);
    tick();              sym("ur_sof", 1'b1, 8'hFB);
    tick();              sym("ur_dA1", 1'b0, 8'hA1);
    tick();              sym("ur_fill0", 1'b1, 8'hBC); chk("ur_busy_fill", 32'(bus.busy), 32'd1);
    tick();              sym("ur_fill1", 1'b1, 8'hBC);
    cyc(1, 0, 1, 8'hA2); sym("ur_fill2", 1'b1, 8'hBC);
    tick();              sym("ur_dA2", 1'b0, 8'hA2);

    // back-to-back pushes while the sequencer cannot pop: fills to DEPTH, 5th dropped
    cyc(1, 1, 0, 8'hC0); sym("ur_eof", 1'b1, 8'hFD); chk("full_stop1", 32'(bus.stopin), 32'd0);
    cyc(1, 0, 0, 8'hC1); sym("full_gap0", 1'b1, 8'hBC);
    cyc(1, 0, 0, 8'hC2); sym("full_gap1", 1'b1, 8'hBC); chk("full_stop3", 32'(bus.stopin), 32'd0);
    cyc(1, 0, 1, 8'hC3); sym("full_idle", 1'b1, 8'hBC); chk("full_stop4", 32'(bus.stopin), 32'd1);
    cyc(1, 0, 0, 8'hEE); sym("full_sof", 1'b1, 8'hFB); chk("full_stop_hold", 32'(bus.stopin), 32'd1);
    tick();              sym("full_dC0", 1'b0, 8'hC0); chk("full_stop_rel", 32'(bus.stopin), 32'd0);
    tick();              sym("full_dC1", 1'b0, 8'hC1);
    tick();              sym("full_dC2", 1'b0, 8'hC2);
    tick();              sym("full_dC3", 1'b0, 8'hC3);
    tick();              sym("full_eof", 1'b1, 8'hFD);
    for (int i = 0; i < 4; i++) begin
      tick();
      sym($sformatf("full_tail%0d", i), 1'b1, 8'hBC);
      chk($sformatf("full_tail_drop%0d", i), 32'(bus.dropout), 32'd0);
    end
    chk("full_empty", 32'(bus.stopin), 32'd0);

    // reset in the middle of a frame
    cyc(1, 1, 0, 8'h61); sym("rst_e0", 1'b1, 8'hBC);
    cyc(1, 0, 0, 8'h62); sym("rst_sof", 1'b1, 8'hFB);
    cyc(1, 0, 1, 8'h63); sym("rst_d61", 1'b0, 8'h61);
    reset_n = 1'b0;
    #1;
    all_zero("rst_async");
    repeat (2) tick();
    all_zero("rst_hold");
    reset_n = 1'b1;
    tick();
    chk("rst_init_start", 32'({bus.startout, bus.pushout}), 32'b10);
    for (int i = 0; i < 5; i++) begin
      tick();
      sym($sformatf("rst_after%0d", i), 1'b1, 8'hBC);
      chk($sformatf("rst_after_flags%0d", i), 32'({bus.busy, bus.dropout}), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
